// File: rtl/alarm_if.sv
// Handshake/bus bundle between the alarm sequencer and its neighbours:
// divided clocks and debounced buttons in, time/alarm/mode/buzzer out.
interface alarm_if;
  logic       tick_1hz;
  logic       tick_1khz;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_inc;
  logic       btn_snooze;
  logic       alarm_on;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] al_hours;
  logic [5:0] al_minutes;
  logic [1:0] mode;
  logic       field;
  logic       ringing;
  logic       buzzer;

  modport master (
    output tick_1hz, tick_1khz, btn_mode, btn_sel, btn_inc, btn_snooze, alarm_on,
    input  hours, minutes, seconds, al_hours, al_minutes, mode, field, ringing, buzzer
  );

  modport slave (
    input  tick_1hz, tick_1khz, btn_mode, btn_sel, btn_inc, btn_snooze, alarm_on,
    output hours, minutes, seconds, al_hours, al_minutes, mode, field, ringing, buzzer
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm clock sequencer: tick edge detect, HH:MM:SS timekeeping, mode FSM and
// ring/snooze alarm FSM with buzzer. Snooze is built only with ALARM_SNOOZE_EN.
module alarm_controller #(
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned SNOOZE_MIN   = 5
) (
  input logic    clk,
  input logic    rst,
  alarm_if.slave bus
);

  localparam int unsigned HW = 5;
  localparam int unsigned MW = 6;
  localparam int unsigned RW = 8;

  typedef enum logic [1:0] {
    M_RUN       = 2'd0,
    M_SET_TIME  = 2'd1,
    M_SET_ALARM = 2'd2
  } mode_t;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW           = 10;
  localparam int unsigned SNOOZE_TICKS = SNOOZE_MIN * 60;
  typedef enum logic [1:0] {AL_IDLE, AL_RING, AL_SNOOZE} al_state_t;
  logic [SW-1:0] snz_q, snz_n;
`else
  typedef enum logic [1:0] {AL_IDLE, AL_RING} al_state_t;
`endif

  logic          prev_1hz_q, prev_1khz_q;
  logic [HW-1:0] hours_q, hours_n, al_hours_q, al_hours_n;
  logic [MW-1:0] minutes_q, minutes_n, seconds_q, seconds_n;
  logic [MW-1:0] al_minutes_q, al_minutes_n;
  mode_t         mode_q, mode_n;
  logic          field_q, field_n;
  al_state_t     al_q, al_n;
  logic [RW-1:0] ring_cnt_q, ring_cnt_n;
  logic          ringing_q, ringing_n;
  logic          buzzer_q, buzzer_n;
  logic          s1_c, k1_c, trig_c;

  assign s1_c = bus.tick_1hz  & ~prev_1hz_q;
  assign k1_c = bus.tick_1khz & ~prev_1khz_q;

  // State register; edge-detect history resets high to suppress a tick at release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_1hz_q   <= 1'b1;
      prev_1khz_q  <= 1'b1;
      hours_q      <= '0;
      minutes_q    <= '0;
      seconds_q    <= '0;
      al_hours_q   <= '0;
      al_minutes_q <= '0;
      mode_q       <= M_RUN;
      field_q      <= 1'b0;
      al_q         <= AL_IDLE;
      ring_cnt_q   <= '0;
      ringing_q    <= 1'b0;
      buzzer_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q        <= '0;
`endif
    end else begin
      prev_1hz_q   <= bus.tick_1hz;
      prev_1khz_q  <= bus.tick_1khz;
      hours_q      <= hours_n;
      minutes_q    <= minutes_n;
      seconds_q    <= seconds_n;
      al_hours_q   <= al_hours_n;
      al_minutes_q <= al_minutes_n;
      mode_q       <= mode_n;
      field_q      <= field_n;
      al_q         <= al_n;
      ring_cnt_q   <= ring_cnt_n;
      ringing_q    <= ringing_n;
      buzzer_q     <= buzzer_n;
`ifdef ALARM_SNOOZE_EN
      snz_q        <= snz_n;
`endif
    end
  end

  always_comb begin
    hours_n      = hours_q;
    minutes_n    = minutes_q;
    seconds_n    = seconds_q;
    al_hours_n   = al_hours_q;
    al_minutes_n = al_minutes_q;
    mode_n       = mode_q;
    field_n      = field_q;
    al_n         = al_q;
    ring_cnt_n   = ring_cnt_q;
    trig_c       = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_n        = snz_q;
`endif

    // Timekeeping with carries; frozen while the time itself is being edited.
    if (s1_c && (mode_q != M_SET_TIME)) begin
      if (seconds_q == MW'(59)) begin
        seconds_n = '0;
        if (minutes_q == MW'(59)) begin
          minutes_n = '0;
          hours_n   = (hours_q == HW'(23)) ? '0 : hours_q + HW'(1);
        end else begin
          minutes_n = minutes_q + MW'(1);
        end
      end else begin
        seconds_n = seconds_q + MW'(1);
      end
    end

    trig_c = s1_c && (mode_q == M_RUN) && bus.alarm_on && (seconds_n == '0) &&
             (hours_n == al_hours_q) && (minutes_n == al_minutes_q);

    // btn_mode is consumed as "stop" while ringing; otherwise it wins over sel/inc.
    if (bus.btn_mode) begin
      if (al_q != AL_RING) begin
        field_n = 1'b0;
        case (mode_q)
          M_RUN: begin
            mode_n    = M_SET_TIME;
            seconds_n = '0;
          end
          M_SET_TIME: mode_n = M_SET_ALARM;
          default:    mode_n = M_RUN;
        endcase
      end
    end else if (mode_q != M_RUN) begin
      if (bus.btn_sel) begin
        field_n = ~field_q;
      end
      if (bus.btn_inc) begin
        if (mode_q == M_SET_TIME) begin
          if (field_q) minutes_n = (minutes_q == MW'(59)) ? '0 : minutes_q + MW'(1);
          else         hours_n   = (hours_q == HW'(23)) ? '0 : hours_q + HW'(1);
        end else begin
          if (field_q) al_minutes_n = (al_minutes_q == MW'(59)) ? '0 : al_minutes_q + MW'(1);
          else         al_hours_n   = (al_hours_q == HW'(23)) ? '0 : al_hours_q + HW'(1);
        end
      end
    end

    case (al_q)
      AL_IDLE: begin
        if (trig_c) begin
          al_n       = AL_RING;
          ring_cnt_n = '0;
        end
      end
      AL_RING: begin
        if (bus.btn_mode || !bus.alarm_on) begin
          al_n = AL_IDLE;
        end else if (bus.btn_snooze) begin
`ifdef ALARM_SNOOZE_EN
          al_n  = AL_SNOOZE;
          snz_n = SW'(SNOOZE_TICKS);
`else
          al_n  = AL_IDLE;
`endif
        end else if (s1_c) begin
          if (ring_cnt_q == RW'(RING_TIMEOUT - 1)) al_n = AL_IDLE;
          else                                      ring_cnt_n = ring_cnt_q + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      AL_SNOOZE: begin
        if (bus.btn_mode || !bus.alarm_on) begin
          al_n = AL_IDLE;
        end else if (s1_c) begin
          snz_n = snz_q - SW'(1);
          if (snz_q == SW'(1)) begin
            al_n       = AL_RING;
            ring_cnt_n = '0;
          end
        end
      end
`endif
      default: al_n = AL_IDLE;
    endcase

    ringing_n = (al_n == AL_RING);
    buzzer_n  = ((al_q == AL_RING) && (al_n == AL_RING)) ? (buzzer_q ^ k1_c) : 1'b0;
  end

  assign bus.hours      = hours_q;
  assign bus.minutes    = minutes_q;
  assign bus.seconds    = seconds_q;
  assign bus.al_hours   = al_hours_q;
  assign bus.al_minutes = al_minutes_q;
  assign bus.mode       = mode_q;
  assign bus.field      = field_q;
  assign bus.ringing    = ringing_q;
  assign bus.buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed plan steps plus a random
// phase, compared every cycle against a seconds-of-day reference model.
module tb_alarm_controller;

  localparam int RT = 60;
  localparam int SM = 5;

  logic clk = 1'b0;
  logic rst;
  bit   ao;
  int   tests = 0;
  int   fails = 0;

  alarm_if bus ();

  alarm_controller #(.RING_TIMEOUT(RT), .SNOOZE_MIN(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as seconds of day, alarm as 0=idle 1=ring 2=snooze.
  int m_tod, m_ah, m_am, m_md, m_fld, m_ast, m_ring_left, m_snz_left;
  bit m_buz, m_prev1, m_prevk;

  task automatic model_reset();
    m_tod = 0; m_ah = 0; m_am = 0; m_md = 0; m_fld = 0;
    m_ast = 0; m_ring_left = 0; m_snz_left = 0; m_buz = 0;
    m_prev1 = 1; m_prevk = 1;
  endtask

  task automatic model_step(input bit t1, tk, bm, bs, bi, bz, on);
    bit s1, k1, trig;
    int old_md, old_ast, old_fld, hh, mm, ss;
    s1 = t1 && !m_prev1;
    k1 = tk && !m_prevk;
    m_prev1 = t1; m_prevk = tk;
    old_md = m_md; old_ast = m_ast; old_fld = m_fld;
    if (s1 && old_md != 1) m_tod = (m_tod + 1) % 86400;
    trig = s1 && old_md == 0 && on && (m_tod % 60 == 0) && (m_tod / 60 == m_ah * 60 + m_am);
    if (bm) begin
      if (old_ast != 1) begin
        m_md = (old_md + 1) % 3;
        m_fld = 0;
        if (m_md == 1) m_tod = m_tod - m_tod % 60;
      end
    end else if (old_md != 0) begin
      if (bs) m_fld = 1 - m_fld;
      if (bi && old_md == 1) begin
        hh = m_tod / 3600; mm = (m_tod / 60) % 60; ss = m_tod % 60;
        if (old_fld == 0) hh = (hh + 1) % 24; else mm = (mm + 1) % 60;
        m_tod = hh * 3600 + mm * 60 + ss;
      end
      if (bi && old_md == 2) begin
        if (old_fld == 0) m_ah = (m_ah + 1) % 24; else m_am = (m_am + 1) % 60;
      end
    end
    case (old_ast)
      0: if (trig) begin m_ast = 1; m_ring_left = RT; end
      1: begin
        if (bm || !on) m_ast = 0;
        else if (bz) begin
`ifdef ALARM_SNOOZE_EN
          m_ast = 2; m_snz_left = SM * 60;
`else
          m_ast = 0;
`endif
        end else if (s1) begin
          m_ring_left--;
          if (m_ring_left == 0) m_ast = 0;
        end
      end
      default: begin
        if (bm || !on) m_ast = 0;
        else if (s1) begin
          m_snz_left--;
          if (m_snz_left == 0) begin m_ast = 1; m_ring_left = RT; end
        end
      end
    endcase
    m_buz = (old_ast == 1 && m_ast == 1) ? (m_buz ^ k1) : 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hours",      32'(bus.hours),      32'(m_tod / 3600));
    chk("minutes",    32'(bus.minutes),    32'((m_tod / 60) % 60));
    chk("seconds",    32'(bus.seconds),    32'(m_tod % 60));
    chk("al_hours",   32'(bus.al_hours),   32'(m_ah));
    chk("al_minutes", 32'(bus.al_minutes), 32'(m_am));
    chk("mode",       32'(bus.mode),       32'(m_md));
    chk("field",      32'(bus.field),      32'(m_fld));
    chk("ringing",    32'(bus.ringing),    32'(m_ast == 1));
    chk("buzzer",     32'(bus.buzzer),     32'(m_buz));
  endtask

  task automatic cyc(input bit t1, tk, bm, bs, bi, bz);
    @(negedge clk);
    bus.tick_1hz = t1; bus.tick_1khz = tk;
    bus.btn_mode = bm; bus.btn_sel = bs; bus.btn_inc = bi; bus.btn_snooze = bz;
    bus.alarm_on = ao;
    model_step(t1, tk, bm, bs, bi, bz, ao);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic sec_edge();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic press(input bit bm, bs, bi, bz);
    cyc(0, 0, bm, bs, bi, bz);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ao = 1'b0;
    bus.tick_1hz = 1'b1; bus.tick_1khz = 1'b0;
    bus.btn_mode = 1'b0; bus.btn_sel = 1'b0; bus.btn_inc = 1'b0;
    bus.btn_snooze = 1'b0; bus.alarm_on = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_ringing", 32'(bus.ringing), 32'd0);

    // Tick held high across reset release must not count.
    rst = 1'b0;
    repeat (10) cyc(1, 0, 0, 0, 0, 0);
    chk("no_spurious_s1", 32'(bus.seconds), 32'd0);

    // Preset 23:59 and alarm 00:01.
    press(1, 0, 0, 0);
    repeat (23) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    repeat (59) press(0, 0, 1, 0);
    chk("preset_hours", 32'(bus.hours), 32'd23);
    chk("preset_minutes", 32'(bus.minutes), 32'd59);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    chk("back_to_run", 32'(bus.mode), 32'd0);
    chk("al_min_set", 32'(bus.al_minutes), 32'd1);
    repeat (58) sec_edge();
    chk("sec_58", 32'(bus.seconds), 32'd58);
    sec_edge();
    chk("pre_wrap_hours", 32'(bus.hours), 32'd23);
    sec_edge();
    chk("wrap_hours", 32'(bus.hours), 32'd0);
    chk("wrap_minutes", 32'(bus.minutes), 32'd0);

    // Ring at 00:01:00, buzzer toggles per k1, timeout after RT seconds.
    ao = 1'b1;
    repeat (59) sec_edge();
    chk("pre_ring", 32'(bus.ringing), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("ring_start", 32'(bus.ringing), 32'd1);
    chk("ring_sec0", 32'(bus.seconds), 32'd0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("buzz_1", 32'(bus.buzzer), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("buzz_0", 32'(bus.buzzer), 32'd0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("buzz_hold", 32'(bus.buzzer), 32'd0);
    repeat (RT - 1) sec_edge();
    chk("ring_before_timeout", 32'(bus.ringing), 32'd1);
    sec_edge();
    chk("ring_timeout", 32'(bus.ringing), 32'd0);

    // Re-arm for 00:03, then snooze.
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    repeat (2) press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    repeat (60) sec_edge();
    chk("ring2_start", 32'(bus.ringing), 32'd1);
    press(0, 0, 0, 1);
    chk("snoozed", 32'(bus.ringing), 32'd0);
    repeat (SM * 60 - 1) sec_edge();
    chk("snooze_299", 32'(bus.ringing), 32'd0);
    sec_edge();
`ifdef ALARM_SNOOZE_EN
    chk("snooze_rering", 32'(bus.ringing), 32'd1);
    press(1, 0, 0, 0);
    chk("mode_stop_ring", 32'(bus.ringing), 32'd0);
    chk("mode_kept", 32'(bus.mode), 32'd0);
`else
    chk("snooze_stop", 32'(bus.ringing), 32'd0);
`endif

    // Ring at 00:09 then reset asynchronously mid-ring.
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    repeat (6) press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    repeat (60) sec_edge();
    cyc(0, 1, 0, 0, 0, 0);
    chk("ring3_buzz", 32'(bus.buzzer), 32'd1);
    @(negedge clk);
    bus.tick_1khz = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ringing", 32'(bus.ringing), 32'd0);
    chk("arst_buzzer", 32'(bus.buzzer), 32'd0);
    chk("arst_mode", 32'(bus.mode), 32'd0);
    chk("arst_minutes", 32'(bus.minutes), 32'd0);
    chk("arst_hours", 32'(bus.hours), 32'd0);
    chk("arst_seconds", 32'(bus.seconds), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // 61 minute increments in SET_ALARM, then mode+inc together.
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    repeat (61) press(0, 0, 1, 0);
    chk("al_min_wrap", 32'(bus.al_minutes), 32'd1);
    chk("al_hr_kept", 32'(bus.al_hours), 32'd0);
    press(1, 0, 1, 0);
    chk("mode_wins", 32'(bus.mode), 32'd0);
    chk("inc_ignored", 32'(bus.al_minutes), 32'd1);

    // Random phase against the model.
    repeat (600) begin
      ao = ($urandom_range(0, 31) != 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Top-level sequencer of the alarm clock. Consumes the divided 1 Hz and 1 kHz clocks from the clock divider as synchronous level signals and edge-detects them into single-cycle ticks. It runs the HH:MM:SS timekeeping counters and the mode state machine (run / set time / set alarm), and drives the ringing/snooze alarm state machine and buzzer. It sits between the clock divider, the debounced button logic and the display driver.

## Interface
Parameters:
- RING_TIMEOUT, 60: seconds the alarm rings before auto-stopping (1..255).
- SNOOZE_MIN, 5: snooze length in minutes (1..15).

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst  in  1  reset; asynchronous, active-high.
- tick_1hz  in  1  1 Hz divided clock, level, synchronous to clk.
- tick_1khz  in  1  1 kHz divided clock, level, synchronous to clk.
- btn_mode  in  1  one-cycle pulse, debounced upstream.
- btn_sel  in  1  one-cycle pulse; toggles the field being edited.
- btn_inc  in  1  one-cycle pulse; increments the field being edited.
- btn_snooze  in  1  one-cycle pulse.
- alarm_on  in  1  level; alarm arm switch.
- hours  out  5  current hour, 0..23.
- minutes  out  6  current minute, 0..59.
- seconds  out  6  current second, 0..59.
- al_hours  out  5  alarm hour, 0..23.
- al_minutes  out  6  alarm minute, 0..59.
- mode  out  2  0 = RUN, 1 = SET_TIME, 2 = SET_ALARM (3 is never driven).
- field  out  1  0 = hours, 1 = minutes.
- ringing  out  1  high in state AL_RING.
- buzzer  out  1  500 Hz square wave while ringing, else 0.

## Operation
- Edge detect:
  - s1 = tick_1hz & ~prev_1hz and k1 = tick_1khz & ~prev_1khz.
  - prev registers reset to 1, so no spurious tick is produced at reset release.
- Timekeeping on s1, when mode is not SET_TIME:
  - seconds 59→0 carries into minutes.
  - minutes 59→0 carries into hours.
  - hours 23→0.
- Mode FSM: RUN →(btn_mode)→ SET_TIME →(btn_mode)→ SET_ALARM →(btn_mode)→ RUN.
  - field resets to 0 on every mode change.
  - btn_sel toggles field only in the SET modes.
- Entering SET_TIME clears seconds to 0. Seconds stay frozen until mode leaves SET_TIME.
- btn_inc in a SET mode increments the selected field of the time (SET_TIME) or the alarm (SET_ALARM).
  - Hours wraps 23→0; minutes wraps 59→0.
  - No carry between fields.
- Alarm FSM, states AL_IDLE, AL_RING, AL_SNOOZE:
  - AL_IDLE→AL_RING requires all of: mode == RUN, alarm_on = 1, and an s1 cycle whose updated value is seconds = 0 and hours:minutes == al_hours:al_minutes.
  - AL_RING→AL_IDLE on any of: btn_mode, alarm_on = 0, or ring counter reaching RING_TIMEOUT s1 ticks.
  - btn_mode while in AL_RING stops the alarm only; the mode is unchanged.
  - AL_RING→AL_SNOOZE on btn_snooze; the snooze counter loads SNOOZE_MIN*60.
  - AL_SNOOZE→AL_RING when the snooze counter, decremented on each s1, reaches 0. The ring counter reloads.
  - AL_SNOOZE→AL_IDLE on alarm_on = 0 or btn_mode.
  - The snooze countdown runs in every mode.
- buzzer toggles on each k1 while in AL_RING. It is forced to 0 on the cycle AL_RING is left.

## Timing
- s1 and k1 are asserted in the same cycle as the rising input level.
- All counter and FSM updates are registered and visible one cycle after s1 or the button pulse.
- ringing rises in the same cycle in which seconds shows 00.
- Simultaneous events:
  - btn_mode with btn_inc or btn_sel: the mode change wins; inc/sel is ignored.
  - btn_inc with s1 in SET_ALARM: both apply.
  - btn_inc on minutes with s1 carry in RUN: impossible, because inc is ignored in RUN.
  - btn_snooze with ring timeout: snooze wins.
- Reset values:
  - All time and alarm registers 0; mode 0; field 0; ringing 0; buzzer 0.
  - Alarm FSM AL_IDLE; all counters 0.
- Reset asserted mid-ring stops the buzzer immediately (asynchronously).

## Configuration
- ALARM_SNOOZE_EN defined: snooze behaves as described above.
- ALARM_SNOOZE_EN undefined:
  - AL_SNOOZE and the snooze counter are not built.
  - btn_snooze in AL_RING acts as stop (→AL_IDLE).
  - btn_snooze is ignored in all other states.

## Test plan
- Reset with tick_1hz held high, release, hold high for 10 cycles → no s1 edge; time stays 00:00:00.
- Preset time 23:59:58 via SET_TIME, return to RUN, apply 2 edges → 00:00:00, with hours wrapping on the second edge.
- Alarm 00:01, alarm_on = 1, run from 00:00:59 → ringing = 1 the cycle seconds = 00; buzzer toggles on each k1; after 60 s1 edges ringing = 0.
- While ringing, btn_snooze (ALARM_SNOOZE_EN) → ringing 0; after exactly 300 s1 edges ringing = 1 again. Without the macro → ringing 0 permanently.
- In SET_ALARM, field = 1, press btn_inc 61 times from 0 → al_minutes = 1 and al_hours unchanged. The same cycle btn_mode + btn_inc → mode = RUN and no increment.
- Assert rst while ringing → ringing, buzzer, mode and time all 0 without any clk edge.
